// File: rtl/sd_pkg.sv
// Shared definitions for the SD SPI-mode card responder and host initialiser.
// Holds command indices, R1 bit positions, the responder FSM encoding and frame length.
// No ports; import with sd_pkg::*.
package sd_pkg;

    localparam int CMD_LEN     = 48;  // start + tx + index + arg + crc7 + end
    localparam int CMD_HDR_LEN = 40;  // bits covered by CRC7

    localparam logic [5:0] CMD0  = 6'd0;
    localparam logic [5:0] CMD8  = 6'd8;
    localparam logic [5:0] CMD41 = 6'd41;
    localparam logic [5:0] CMD55 = 6'd55;

    // R1 response bit positions
    localparam int R1_IDLE      = 0;
    localparam int R1_ERASE_RST = 1;
    localparam int R1_ILLEGAL   = 2;
    localparam int R1_CRC_ERR   = 3;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_RX,
        ST_DECODE,
        ST_NCR,
        ST_TX
    } rsp_state_t;

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), MSB-first, zero initial value.
// Ports: SD_CLK, rst_n (async, active low), clr (synchronous clear), en (absorb din), crc (remainder).
// One bit per enabled cycle; clr has priority over en.
module sd_crc7 (
    input  logic       SD_CLK,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    logic fb;
    assign fb = din ^ crc[6];

    always_ff @(posedge SD_CLK or negedge rst_n) begin
        if (!rst_n) begin
            crc <= 7'd0;
        end else if (clr) begin
            crc <= 7'd0;
        end else if (en) begin
            crc <= {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
    end

endmodule

// File: rtl/sd_spi_card_responder.sv
// Card-side SD SPI-mode responder: frames 48-bit commands on SD_DATAIN, answers R1/R7 on SD_DATAOUT.
// Ports: SD_CLK/rst_n/SD_CS/SD_DATAIN in; SD_DATAOUT (idles 1), card_idle, card_ready, cmd_strobe, cmd_index, cmd_arg out.
// Optional CRC7 command check when SD_CARD_CRC7_CHECK_EN is defined; otherwise the CRC field is ignored.
module sd_spi_card_responder
    import sd_pkg::*;
#(
    parameter int NCR_BYTES   = 1,
    parameter int ACMD41_BUSY = 3
) (
    input  logic        SD_CLK,
    input  logic        rst_n,
    input  logic        SD_CS,
    input  logic        SD_DATAIN,
    output logic        SD_DATAOUT,
    output logic        card_idle,
    output logic        card_ready,
    output logic        cmd_strobe,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg
);

    localparam int BUSY_W = (ACMD41_BUSY > 0) ? $clog2(ACMD41_BUSY + 1) : 1;
    // DECODE itself is the first filler cycle, so NCR holds for one less.
    localparam logic [5:0] NCR_CNT = 6'(8 * NCR_BYTES - 1);

    rsp_state_t state, state_nxt;

    logic [39:0]       rx_sr;     // first 40 bits of the frame: start, tx, index, arg
    logic [39:0]       tx_sr;     // response, left aligned
    logic [5:0]        cnt;
    logic              long_q;
    logic              spi_mode, app_cmd;
    logic [BUSY_W-1:0] busy;

    logic [5:0]        dec_idx;
    logic [31:0]       dec_arg;
    logic [7:0]        r1;
    logic [39:0]       dec_tx;
    logic              dec_long, dec_respond, crc_ok;
    logic              spi_mode_nxt, idle_nxt, ready_nxt, app_nxt;
    logic [BUSY_W-1:0] busy_nxt;

`ifdef SD_CARD_CRC7_CHECK_EN
    logic [6:0] crc_res;
    logic       crc_clr, crc_en;
    // Clearing in HUNT stands in for the always-zero start bit. Bits 1..46
    // (header plus received CRC) are absorbed; a good frame leaves remainder 0.
    assign crc_clr = (state == ST_HUNT);
    assign crc_en  = (state == ST_RX) && (cnt <= 6'd46);
    sd_crc7 u_crc7 (
        .SD_CLK (SD_CLK),
        .rst_n  (rst_n),
        .clr    (crc_clr),
        .en     (crc_en),
        .din    (SD_DATAIN),
        .crc    (crc_res)
    );
    assign crc_ok = (crc_res == 7'd0);
`else
    assign crc_ok = 1'b1;
`endif

    // Command decode: response and next card flags, applied in DECODE.
    always_comb begin
        dec_idx      = rx_sr[37:32];
        dec_arg      = rx_sr[31:0];
        spi_mode_nxt = spi_mode;
        idle_nxt     = card_idle;
        ready_nxt    = card_ready;
        app_nxt      = 1'b0;
        busy_nxt     = busy;
        dec_respond  = 1'b1;
        dec_long     = 1'b0;
        r1           = 8'h00;
        r1[R1_IDLE]  = card_idle;
        if (!spi_mode && (dec_idx != CMD0)) begin
            dec_respond = 1'b0;
        end else if (!crc_ok) begin
            app_nxt        = app_cmd;   // command not executed: flags untouched
            r1[R1_CRC_ERR] = 1'b1;
        end else begin
            case (dec_idx)
                CMD0: begin
                    spi_mode_nxt = 1'b1;
                    idle_nxt     = 1'b1;
                    ready_nxt    = 1'b0;
                    busy_nxt     = BUSY_W'(ACMD41_BUSY);
                    r1           = 8'h01;
                end
                CMD8: begin
                    if (dec_arg[11:8] == 4'h1) dec_long = 1'b1;
                    else                       r1[R1_ILLEGAL] = 1'b1;
                end
                CMD55: app_nxt = 1'b1;
                CMD41: begin
                    if (!app_cmd) begin
                        r1[R1_ILLEGAL] = 1'b1;
                    end else if (busy != '0) begin
                        busy_nxt = busy - BUSY_W'(1);
                    end else begin
                        idle_nxt  = 1'b0;
                        ready_nxt = 1'b1;
                        r1        = 8'h00;
                    end
                end
                default: r1[R1_ILLEGAL] = 1'b1;
            endcase
        end
        dec_tx = dec_long ? {r1, 24'h000001, dec_arg[7:0]} : {r1, 32'h0};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_HUNT:   if (!SD_CS && !SD_DATAIN) state_nxt = ST_RX;
            // Framing (start=0, tx=1, end=1) is judged once the end bit arrives.
            ST_RX:     if (cnt == 6'd47)
                           state_nxt = (SD_DATAIN && (rx_sr[39:38] == 2'b01)) ? ST_DECODE : ST_HUNT;
            ST_DECODE: state_nxt = dec_respond ? ST_NCR : ST_HUNT;
            ST_NCR:    if (cnt == 6'd1) state_nxt = ST_TX;
            ST_TX:     if (cnt == 6'd1) state_nxt = ST_HUNT;
            default:   state_nxt = ST_HUNT;
        endcase
        if (SD_CS) state_nxt = ST_HUNT;
    end

    always_ff @(posedge SD_CLK or negedge rst_n) begin
        if (!rst_n) state <= ST_HUNT;
        else        state <= state_nxt;
    end

    always_ff @(posedge SD_CLK or negedge rst_n) begin
        if (!rst_n) begin
            rx_sr      <= '0;
            tx_sr      <= '0;
            cnt        <= '0;
            long_q     <= 1'b0;
            spi_mode   <= 1'b0;
            app_cmd    <= 1'b0;
            busy       <= BUSY_W'(ACMD41_BUSY);
            card_idle  <= 1'b0;
            card_ready <= 1'b0;
            cmd_strobe <= 1'b0;
            cmd_index  <= '0;
            cmd_arg    <= '0;
        end else begin
            cmd_strobe <= (state == ST_DECODE);
            case (state)
                ST_HUNT: begin
                    cnt   <= 6'd1;
                    rx_sr <= {39'd0, SD_DATAIN};
                end
                ST_RX: begin
                    cnt <= cnt + 6'd1;
                    if (cnt < 6'd40) rx_sr <= {rx_sr[38:0], SD_DATAIN};
                end
                ST_DECODE: begin
                    cmd_index  <= dec_idx;
                    cmd_arg    <= dec_arg;
                    spi_mode   <= spi_mode_nxt;
                    card_idle  <= idle_nxt;
                    card_ready <= ready_nxt;
                    app_cmd    <= app_nxt;
                    busy       <= busy_nxt;
                    tx_sr      <= dec_tx;
                    long_q     <= dec_long;
                    cnt        <= NCR_CNT;
                end
                ST_NCR: cnt <= (cnt == 6'd1) ? (long_q ? 6'd40 : 6'd8) : cnt - 6'd1;
                ST_TX: begin
                    tx_sr <= {tx_sr[38:0], 1'b0};
                    cnt   <= cnt - 6'd1;
                end
                default: ;
            endcase
        end
    end

    // MISO changes on the falling edge; CS high forces it to 1 at the next one.
    always_ff @(negedge SD_CLK or negedge rst_n) begin
        if (!rst_n) SD_DATAOUT <= 1'b1;
        else        SD_DATAOUT <= ((state == ST_TX) && !SD_CS) ? tx_sr[39] : 1'b1;
    end

endmodule

// File: tb/tb_sd_spi_card_responder.sv
// Self-checking bench for sd_spi_card_responder (NCR_BYTES=2, ACMD41_BUSY=2).
// Host drives MOSI on falling edges; expected responses queue up as commands are sent.
// Define SD_CARD_CRC7_CHECK_EN for both RTL and bench to exercise the CRC path.
module tb_sd_spi_card_responder;

    localparam int NCR  = 2;
    localparam int BUSY = 2;

    logic        SD_CLK = 1'b0;
    logic        rst_n;
    logic        SD_CS;
    logic        SD_DATAIN;
    logic        SD_DATAOUT;
    logic        card_idle;
    logic        card_ready;
    logic        cmd_strobe;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;

    always #5 SD_CLK = ~SD_CLK;

    sd_spi_card_responder #(.NCR_BYTES(NCR), .ACMD41_BUSY(BUSY)) dut (
        .SD_CLK     (SD_CLK),
        .rst_n      (rst_n),
        .SD_CS      (SD_CS),
        .SD_DATAIN  (SD_DATAIN),
        .SD_DATAOUT (SD_DATAOUT),
        .card_idle  (card_idle),
        .card_ready (card_ready),
        .cmd_strobe (cmd_strobe),
        .cmd_index  (cmd_index),
        .cmd_arg    (cmd_arg)
    );

    int vectors     = 0;
    int miscompares = 0;
    int strobe_cnt  = 0;

    always @(negedge SD_CLK) if (cmd_strobe === 1'b1) strobe_cnt++;

    typedef struct {
        bit          none;
        int          len;
        logic [39:0] val;
    } exp_t;
    exp_t exp_q[$];

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    task automatic push(input bit none, input int len, input logic [39:0] val);
        exp_t e;
        e.none = none;
        e.len  = len;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    // Drives the first nbits of a frame; the last bit is sampled at the next posedge.
    task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg,
                            input bit bad_crc, input int nbits);
        logic [47:0] f;
        f = {2'b01, idx, arg, crc7({2'b01, idx, arg}), 1'b1};
        if (bad_crc) f[1] = ~f[1];
        for (int i = 47; i > 47 - nbits; i--) begin
            @(negedge SD_CLK);
            SD_CS     = 1'b0;
            SD_DATAIN = f[i];
        end
    endtask

    task automatic expect_resp(input string tag);
        exp_t        e;
        logic [39:0] got;
        int          bad;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = exp_q.pop_front();
        @(posedge SD_CLK);  // end bit sampled here
        bad = 0;
        repeat (e.none ? 64 : 8 * NCR) begin
            @(posedge SD_CLK);
            if (SD_DATAOUT !== 1'b1) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL %s idle/filler: %0d non-one bits seen, required 0", tag, bad);
        end
        if (!e.none) begin
            got = '0;
            for (int i = 0; i < e.len; i++) begin
                @(posedge SD_CLK);
                got = {got[38:0], SD_DATAOUT};
            end
            vectors++;
            if (got !== e.val) begin
                miscompares++;
                $display("FAIL %s response: got %h, required %h", tag, got, e.val);
            end
        end
    endtask

    task automatic check_flags(input string tag, input logic exp_idle, input logic exp_ready);
        @(negedge SD_CLK);
        vectors++;
        if (card_idle !== exp_idle || card_ready !== exp_ready) begin
            miscompares++;
            $display("FAIL %s flags: idle=%b ready=%b, required idle=%b ready=%b",
                     tag, card_idle, card_ready, exp_idle, exp_ready);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        SD_CS     = 1'b1;
        SD_DATAIN = 1'b1;
        #23;
        vectors++;
        if ({SD_DATAOUT, card_idle, card_ready, cmd_strobe} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_bits: dout/idle/ready/strobe=%b, required 1000",
                     {SD_DATAOUT, card_idle, card_ready, cmd_strobe});
        end
        vectors++;
        if (cmd_index !== 6'd0 || cmd_arg !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_cmd: index=%0d arg=%h, required 0/0", cmd_index, cmd_arg);
        end
        @(negedge SD_CLK);
        rst_n = 1'b1;
        repeat (3) @(negedge SD_CLK);
    endtask

    task automatic test_pre_cmd0();
        push(1, 0, 40'h0);
        send_cmd(6'd8, 32'h000001AA, 0, 48);
        expect_resp("cmd8_before_cmd0");
        check_flags("pre_cmd0", 1'b0, 1'b0);
    endtask

    task automatic test_cmd0();
        int s0;
        s0 = strobe_cnt;
        push(0, 8, 40'h01);
        send_cmd(6'd0, 32'h0, 0, 48);
        expect_resp("cmd0");
        check_flags("cmd0", 1'b1, 1'b0);
        vectors++;
        if (strobe_cnt - s0 != 1 || cmd_index !== 6'd0) begin
            miscompares++;
            $display("FAIL cmd0_strobe: pulses=%0d index=%0d, required 1/0", strobe_cnt - s0, cmd_index);
        end
    endtask

    task automatic test_cmd8();
        push(0, 40, 40'h01_000001AA);
        send_cmd(6'd8, 32'h000001AA, 0, 48);
        expect_resp("cmd8_r7");
        vectors++;
        if (cmd_index !== 6'd8 || cmd_arg !== 32'h000001AA) begin
            miscompares++;
            $display("FAIL cmd8_latch: index=%0d arg=%h, required 8/000001aa", cmd_index, cmd_arg);
        end
        push(0, 8, 40'h05);
        send_cmd(6'd8, 32'h000002AA, 0, 48);
        expect_resp("cmd8_bad_voltage");
    endtask

    task automatic test_illegal();
        push(0, 8, 40'h05);
        send_cmd(6'd17, 32'h0, 0, 48);
        expect_resp("cmd17_idle");
    endtask

    task automatic test_acmd41();
        for (int i = 0; i <= BUSY; i++) begin
            push(0, 8, 40'h01);
            send_cmd(6'd55, 32'h0, 0, 48);
            expect_resp("cmd55");
            push(0, 8, (i < BUSY) ? 40'h01 : 40'h00);
            send_cmd(6'd41, 32'h40000000, 0, 48);
            expect_resp("acmd41");
            check_flags("acmd41_step", (i < BUSY) ? 1'b1 : 1'b0, (i < BUSY) ? 1'b0 : 1'b1);
        end
        push(0, 8, 40'h00);
        send_cmd(6'd55, 32'h0, 0, 48);
        expect_resp("cmd55_ready");
        push(0, 8, 40'h00);
        send_cmd(6'd41, 32'h40000000, 0, 48);
        expect_resp("acmd41_repeat");
        push(0, 8, 40'h04);
        send_cmd(6'd41, 32'h40000000, 0, 48);
        expect_resp("cmd41_no_app");
    endtask

    task automatic test_cs_abort();
        int s0;
        int bad;
        s0 = strobe_cnt;
        push(1, 0, 40'h0);
        send_cmd(6'd0, 32'h0, 0, 20);
        @(negedge SD_CLK);
        SD_CS     = 1'b1;
        SD_DATAIN = 1'b1;
        expect_resp("cmd0_cs_abort_rx");
        check_flags("after_rx_abort", 1'b0, 1'b1);
        vectors++;
        if (strobe_cnt != s0) begin
            miscompares++;
            $display("FAIL rx_abort_strobe: pulses=%0d, required 0", strobe_cnt - s0);
        end
        // abort two bits into an R7 whose next bit would be 0
        send_cmd(6'd8, 32'h000001AA, 0, 48);
        @(posedge SD_CLK);
        repeat (8 * NCR + 2) @(posedge SD_CLK);
        #1 SD_CS = 1'b1;
        @(negedge SD_CLK);
        #1;
        vectors++;
        if (SD_DATAOUT !== 1'b1) begin
            miscompares++;
            $display("FAIL tx_abort_dout: got %b, required 1", SD_DATAOUT);
        end
        bad = 0;
        repeat (40) begin
            @(posedge SD_CLK);
            if (SD_DATAOUT !== 1'b1) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL tx_abort_quiet: %0d non-one bits, required 0", bad);
        end
        push(0, 8, 40'h01);
        send_cmd(6'd0, 32'h0, 0, 48);
        expect_resp("cmd0_after_abort");
        check_flags("cmd0_after_abort", 1'b1, 1'b0);
    endtask

    task automatic test_crc();
`ifdef SD_CARD_CRC7_CHECK_EN
        push(0, 8, 40'h09);
        send_cmd(6'd8, 32'h000001AA, 1, 48);
        expect_resp("cmd8_bad_crc");
        push(0, 40, 40'h01_000001AA);
        send_cmd(6'd8, 32'h000001AA, 0, 48);
        expect_resp("cmd8_after_bad_crc");
`else
        // CRC field ignored: a corrupted CRC still gets the normal R7
        push(0, 40, 40'h01_000001AA);
        send_cmd(6'd8, 32'h000001AA, 1, 48);
        expect_resp("cmd8_crc_ignored");
`endif
    endtask

    task automatic test_reset_mid();
        int bad;
        send_cmd(6'd55, 32'h0, 0, 48);
        @(posedge SD_CLK);
        repeat (3) @(posedge SD_CLK);
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({SD_DATAOUT, card_idle, card_ready} !== 3'b100 || cmd_index !== 6'd0 || cmd_arg !== 32'd0) begin
            miscompares++;
            $display("FAIL mid_reset: dout/idle/ready=%b index=%0d arg=%h, required 100/0/0",
                     {SD_DATAOUT, card_idle, card_ready}, cmd_index, cmd_arg);
        end
        @(negedge SD_CLK);
        rst_n = 1'b1;
        bad = 0;
        repeat (48) begin
            @(posedge SD_CLK);
            if (SD_DATAOUT !== 1'b1) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL mid_reset_partial: %0d non-one bits, required 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_pre_cmd0();
        test_cmd0();
        test_cmd8();
        test_illegal();
        test_crc();
        test_acmd41();
        test_cs_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sd_spi_card_responder.md
Name: sd_spi_card_responder

Overview:
- Card-side (responder) model of the SD SPI-mode initialisation protocol.
- Receives 48-bit host commands on SD_DATAIN while SD_CS is low and returns R1/R7 responses on SD_DATAOUT.
- Emulates a card through CMD0, CMD8, CMD55 and ACMD41, so the host initialiser can be closed-loop verified and demonstrated on FPGA without a physical card.

Parameters:
- NCR_BYTES, 1: number of 0xFF filler bytes between a command end bit and the response MSB; legal range 1..8.
- ACMD41_BUSY, 3: number of ACMD41 commands answered "still idle" (0x01) before the card answers 0x00.

Ports:
- SD_CLK  input  1  SPI clock; MOSI sampled on rising edge, MISO updated on falling edge.
- rst_n  input  1  asynchronous, active-low reset.
- SD_CS  input  1  chip select, active low.
- SD_DATAIN  input  1  host-to-card serial data (MOSI).
- SD_DATAOUT  output  1  card-to-host serial data (MISO); idles at 1.
- card_idle  output  1  R1 in_idle_state flag.
- card_ready  output  1  high once ACMD41 has returned 0x00.
- cmd_strobe  output  1  one-SD_CLK pulse when a well-framed command is decoded.
- cmd_index  output  6  last decoded command index.
- cmd_arg  output  32  last decoded argument.

Behaviour:
- Reset is asynchronous on rst_n (active low); clock is SD_CLK.
- Reset values: SD_DATAOUT=1, card_idle=0, card_ready=0, cmd_strobe=0, cmd_index=0, cmd_arg=0. Internal flags spi_mode=0, app_cmd=0, busy counter=ACMD41_BUSY, FSM=HUNT.
- FSM states:
  - HUNT: on a rising edge with SD_CS=0 and SD_DATAIN=0 (start bit), go to RX with bit count 1.
  - RX: shift in bits until 48 are held.
    - Transmission bit (second bit) = 0 → discard, return to HUNT.
    - End bit (bit 0) = 0 → discard silently, return to HUNT.
  - DECODE: one cycle. Pulse cmd_strobe, latch cmd_index and cmd_arg, compute the response.
  - NCR: drive 1 for NCR_BYTES*8 cycles.
  - TX: shift the response out MSB first (8 bits for R1, 40 bits for R7), then go to HUNT.
- Timing: if the end bit is sampled at rising edge E, the response MSB is valid at rising edge E+8*NCR_BYTES+1.
- SD_DATAIN is ignored during NCR and TX.
- Command decode (R1 = {0, 0, 0, 0, crc_err, illegal, 0, idle}):
  - Before spi_mode is set: every command except CMD0 gets no response. SD_DATAOUT stays 1 and the FSM returns to HUNT.
  - CMD0: set spi_mode=1 and card_idle=1; clear card_ready and app_cmd; reload the busy counter; send R1=0x01.
  - CMD8: if arg[11:8]=4'h1, send R7 = {R1, 24'h000001, arg[7:0]}. Otherwise send R1 with the illegal bit set.
  - CMD55: set app_cmd; send R1.
  - CMD41 with app_cmd=1:
    - Busy counter nonzero: decrement it, send 0x01.
    - Busy counter zero: clear card_idle, set card_ready, send 0x00.
  - Any other index, or CMD41 without app_cmd: R1 = idle | illegal (0x05 while idle).
  - app_cmd clears after any decoded command other than CMD55.
- SD_CS rising during RX, NCR or TX: abort immediately. SD_DATAOUT=1 on the next falling edge, FSM to HUNT, card flags unchanged.
- rst_n asserted mid-operation: all state returns to reset values at once; no partial response.
- After card_ready, a repeated ACMD41 returns 0x00.

Optional Feature:
- Macro: SD_CARD_CRC7_CHECK_EN.
- Defined: the CRC7 over the first 40 bits is compared with bits [7:1]. On mismatch, the command is not executed (no flag changes) and the response is R1 with crc_err set (0x09 while idle).
- Undefined: the CRC field is ignored and no CRC logic is instantiated.

Decomposition:
- Shared package sd_pkg holds:
  - command index constants CMD0, CMD8, CMD41, CMD55;
  - R1 bit positions;
  - responder FSM state encoding;
  - the 48-bit command length constant.
- Sub-module sd_crc7: serial CRC7 (polynomial x^7+x^3+1) with clear/enable, shared with the host side. Instantiated only under SD_CARD_CRC7_CHECK_EN.

Test Plan:
- CS low, CMD0 sent as 40 00 00 00 00 95 → 8*NCR_BYTES ones, then R1=0x01; card_idle=1; cmd_strobe pulses once with cmd_index=0.
- CMD8, arg 0x000001AA → R7 0x01_000001AA.
- With ACMD41_BUSY=2, send CMD55+ACMD41 three times → ACMD41 responses 0x01, 0x01, 0x00; card_ready rises after the third; card_idle=0.
- CMD17 while idle → 0x05. CMD8 before any CMD0 → SD_DATAOUT stays 1 for 64 cycles.
- SD_CS deasserted after 20 bits of CMD0 → no response. A following full CMD0 → 0x01 at the correct latency.
- With SD_CARD_CRC7_CHECK_EN defined, CMD8 with a corrupted CRC → 0x09. The next correct CMD8 → normal R7.
